// File: rtl/rr_sel_arbiter4_if.sv
// rr_sel_arbiter4_if -- request/select bundle between the sources, the
// round-robin select arbiter and the downstream 4:1 data mux.
//   req       : request per source (bit i = source i)
//   done      : consumer has taken the currently selected data
//   s         : binary select code for the 4:1 mux
//   gnt       : one-hot grant, all-zero when nothing is granted
//   gnt_valid : high while a grant is held and s is meaningful
//   timeout   : one-cycle pulse after a grant was force-released
// master = requester/consumer side, slave = arbiter side.
interface rr_sel_arbiter4_if;
  logic [3:0] req;
  logic       done;
  logic [1:0] s;
  logic [3:0] gnt;
  logic       gnt_valid;
  logic       timeout;

  modport master (
    output req, done,
    input  s, gnt, gnt_valid, timeout
  );

  modport slave (
    input  req, done,
    output s, gnt, gnt_valid, timeout
  );
endinterface

// File: rtl/rr_sel_arbiter4.sv
// rr_sel_arbiter4 -- 4-source round-robin arbiter producing the select code
// for a downstream 4:1 mux. A grant is held until done, until the granted
// request drops, or until it has been held TIMEOUT cycles (force release,
// flagged by a one-cycle timeout pulse). Every release is followed by one
// IDLE cycle. All outputs are registered.
//   clk : single clock, rising edge
//   rst : synchronous, active-high reset
//   bus : rr_sel_arbiter4_if.slave (req/done in; s/gnt/gnt_valid/timeout out)
//
// state | meaning
// IDLE  | no grant held; s keeps last value; searching for next requester
// GRANT | grant held on source s; hold counter running
module rr_sel_arbiter4 #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                rst,
  rr_sel_arbiter4_if.slave    bus
);

  localparam logic [7:0] TO_CNT = 8'(TIMEOUT);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t     state_q, state_d;
  logic [1:0] s_q, s_d;
  logic [3:0] gnt_q, gnt_d;
  logic       gnt_valid_q, gnt_valid_d;
  logic       timeout_q, timeout_d;
  logic [7:0] hold_q, hold_d;
  logic [1:0] last_ptr_q, last_ptr_d;

  logic       pick_found;
  logic [1:0] pick_idx;
  logic [1:0] cand;
  logic [7:0] hold_inc;
  logic       expire;
  logic       rel_done;
  logic       rel_drop;

  // Rotating search starting just above last_ptr; the 2-bit add wraps mod 4,
  // and k=4 truncates to 0 so last_ptr itself is examined last.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = 2'd0;
    cand       = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      cand = last_ptr_q + 2'(k);
      if (!pick_found && bus.req[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // Hold counter saturates at TIMEOUT; expiry is seen in the cycle whose
  // increment would reach TIMEOUT, so a grant lasts at most TIMEOUT cycles.
  always_comb begin
    hold_inc = (hold_q == TO_CNT) ? hold_q : hold_q + 8'd1;
    expire   = (hold_inc == TO_CNT);
    rel_done = bus.done;
    rel_drop = !bus.req[s_q];
  end

  always_comb begin
    state_d     = state_q;
    s_d         = s_q;
    gnt_d       = gnt_q;
    gnt_valid_d = gnt_valid_q;
    timeout_d   = 1'b0;
    hold_d      = hold_q;
    last_ptr_d  = last_ptr_q;
    unique case (state_q)
      IDLE: begin
        gnt_d       = 4'b0000;
        gnt_valid_d = 1'b0;
        if (pick_found) begin
          state_d     = GRANT;
          s_d         = pick_idx;
          gnt_d       = 4'b0001 << pick_idx;
          gnt_valid_d = 1'b1;
          last_ptr_d  = pick_idx;
          hold_d      = 8'd0;
        end
      end
      GRANT: begin
        hold_d = hold_inc;
        if (rel_done || rel_drop || expire) begin
          state_d     = IDLE;
          gnt_d       = 4'b0000;
          gnt_valid_d = 1'b0;
          // Only a pure expiry is a forced release; done or a dropped
          // request on the same cycle counts as a normal release.
          timeout_d   = expire && !rel_done && !rel_drop;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      s_q         <= 2'b00;
      gnt_q       <= 4'b0000;
      gnt_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
      hold_q      <= 8'd0;
      last_ptr_q  <= 2'd3;
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      gnt_q       <= gnt_d;
      gnt_valid_q <= gnt_valid_d;
      timeout_q   <= timeout_d;
      hold_q      <= hold_d;
      last_ptr_q  <= last_ptr_d;
    end
  end

  assign bus.s         = s_q;
  assign bus.gnt       = gnt_q;
  assign bus.gnt_valid = gnt_valid_q;
  assign bus.timeout   = timeout_q;

endmodule

// File: tb/tb_rr_sel_arbiter4.sv
// tb_rr_sel_arbiter4 -- directed and random checks of rr_sel_arbiter4
// against a cycle-level behavioural model of the arbitration rules.
module tb_rr_sel_arbiter4;
  localparam int TO = 15;

  logic clk;
  logic rst;
  rr_sel_arbiter4_if bus ();

  rr_sel_arbiter4 #(.TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // behavioural model state
  bit m_busy;
  int m_s;
  int m_last;
  int m_held;
  bit m_to;

  int obs_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input logic [3:0] r, input logic d, input logic rs);
    if (rs) begin
      m_busy = 0; m_s = 0; m_last = 3; m_held = 0; m_to = 0;
    end else if (!m_busy) begin
      m_to = 0;
      if (r != 4'b0000) begin
        for (int j = 1; j <= 4; j++) begin
          int idx;
          idx = (m_last + j) % 4;
          if (r[idx]) begin
            m_busy = 1; m_s = idx; m_last = idx; m_held = 0;
            break;
          end
        end
      end
    end else begin
      m_to = 0;
      m_held = m_held + 1;
      if (d || !r[m_s] || m_held >= TO) begin
        m_to   = !d && r[m_s] && (m_held >= TO);
        m_busy = 0;
      end
    end
  endtask

  task automatic check_outputs();
    logic [3:0] exp_gnt;
    exp_gnt = m_busy ? (4'b0001 << m_s) : 4'b0000;
    chk("s", 32'(bus.s), 32'(m_s));
    chk("gnt", 32'(bus.gnt), 32'(exp_gnt));
    chk("gnt_valid", 32'(bus.gnt_valid), 32'(m_busy));
    chk("timeout", 32'(bus.timeout), 32'(m_to));
    chk("onehot", 32'($countones(bus.gnt) <= 1), 32'(1));
    chk("gv_eq_or_gnt", 32'(bus.gnt_valid), 32'(|bus.gnt));
  endtask

  task automatic tick(input logic [3:0] r, input logic d, input logic rs);
    bus.req  = r;
    bus.done = d;
    rst      = rs;
    @(posedge clk);
    model_step(r, d, rs);
    #1;
    check_outputs();
  endtask

  initial begin
    int n_gv;
    int n_to;
    logic [3:0] r;
    logic d;
    bus.req = 4'b0000; bus.done = 1'b0; rst = 1'b1;
    m_busy = 0; m_s = 0; m_last = 3; m_held = 0; m_to = 0;

    // reset state
    tick(4'b0000, 1'b0, 1'b1);
    tick(4'b0000, 1'b0, 1'b1);
    chk("rst_s", 32'(bus.s), 32'(0));
    chk("rst_gnt", 32'(bus.gnt), 32'(0));

    // round robin with all requesting, done one cycle into each grant
    obs_q.delete();
    for (int i = 0; i < 10; i++) begin
      tick(4'b1111, m_busy, 1'b0);
      if (bus.gnt_valid) obs_q.push_back(int'(bus.s));
    end
    chk("rr_count", 32'(obs_q.size()), 32'(5));
    if (obs_q.size() == 5) begin
      chk("rr_g0", 32'(obs_q[0]), 32'(0));
      chk("rr_g1", 32'(obs_q[1]), 32'(1));
      chk("rr_g2", 32'(obs_q[2]), 32'(2));
      chk("rr_g3", 32'(obs_q[3]), 32'(3));
      chk("rr_g4", 32'(obs_q[4]), 32'(0));
    end

    // last_ptr=1, only source 0 requests -> wrap to 0
    tick(4'b0010, 1'b0, 1'b0);
    tick(4'b0010, 1'b1, 1'b0);
    tick(4'b0001, 1'b0, 1'b0);
    chk("wrap_s", 32'(bus.s), 32'(0));
    chk("wrap_gnt", 32'(bus.gnt), 32'(4'b0001));
    tick(4'b0001, 1'b1, 1'b0);

    // timeout on source 2, then hand over to source 1
    tick(4'b0100, 1'b0, 1'b0);
    n_gv = 1; n_to = 0;
    for (int i = 0; i < 40; i++) begin
      tick(4'b0110, 1'b0, 1'b0);
      if (bus.timeout) n_to++;
      if (bus.gnt_valid) n_gv++;
      else break;
    end
    chk("to_hold_cycles", 32'(n_gv), 32'(TO));
    chk("to_pulse_at_idle", 32'(bus.timeout), 32'(1));
    tick(4'b0110, 1'b0, 1'b0);
    if (bus.timeout) n_to++;
    chk("to_pulse_count", 32'(n_to), 32'(1));
    chk("to_next_src", 32'(bus.s), 32'(1));

    // source 1 drops its request -> plain release
    tick(4'b0100, 1'b0, 1'b0);
    chk("drop_gv", 32'(bus.gnt_valid), 32'(0));
    chk("drop_to", 32'(bus.timeout), 32'(0));
    tick(4'b0000, 1'b0, 1'b0);
    tick(4'b0000, 1'b0, 1'b0);

    // done coinciding with expiry wins, no timeout pulse
    tick(4'b0001, 1'b0, 1'b0);
    for (int i = 0; i < TO - 1; i++) tick(4'b0001, 1'b0, 1'b0);
    tick(4'b0001, 1'b1, 1'b0);
    chk("coinc_gv", 32'(bus.gnt_valid), 32'(0));
    chk("coinc_to", 32'(bus.timeout), 32'(0));
    tick(4'b0000, 1'b0, 1'b0);
    chk("coinc_to_late", 32'(bus.timeout), 32'(0));

    // reset mid-grant on source 3
    tick(4'b1000, 1'b0, 1'b0);
    chk("g3_s", 32'(bus.s), 32'(3));
    tick(4'b1000, 1'b0, 1'b1);
    chk("rstg_gnt", 32'(bus.gnt), 32'(0));
    chk("rstg_s", 32'(bus.s), 32'(0));
    chk("rstg_gv", 32'(bus.gnt_valid), 32'(0));
    chk("rstg_to", 32'(bus.timeout), 32'(0));
    tick(4'b1000, 1'b0, 1'b0);
    chk("rstg_next_s", 32'(bus.s), 32'(3));
    chk("rstg_next_gnt", 32'(bus.gnt), 32'(4'b1000));

    // random traffic: sticky requests, occasional done and reset
    r = 4'b0000;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0) r = 4'($urandom_range(0, 15));
      d = ($urandom_range(0, 9) == 0);
      tick(r, d, ($urandom_range(0, 149) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
